// File: rtl/apr_cond_bank.sv
// Condition/error flag bank: per-channel latched errors, interrupt enables, first-error capture.
// Define APR_COND_COUNT_EN to add per-channel 4-bit saturating occurrence counters.
module apr_cond_bank #(
  parameter int              NCH       = 8,
  parameter logic [NCH-1:0]  EDGE_MASK = '0,
  parameter int              IW        = $clog2(NCH)
) (
  input  logic           clk,
  input  logic           RESET_N,
  input  logic [NCH-1:0] ebus_data,
  input  logic           SEL_SET,
  input  logic           SEL_CLR,
  input  logic           SEL_EN,
  input  logic           SEL_DIS,
  input  logic [NCH-1:0] cond,
`ifdef APR_COND_COUNT_EN
  input  logic [IW-1:0]  cnt_sel,
  output logic [3:0]     cnt_data,
`endif
  output logic [NCH-1:0] ERR,
  output logic [NCH-1:0] INT_EN,
  output logic           APR_INTERRUPT,
  output logic           FIRST_VLD,
  output logic [IW-1:0]  FIRST_IDX
);

  logic [NCH-1:0] r_cond_q;
  logic [NCH-1:0] r_err;
  logic [NCH-1:0] r_int_en;
  logic           r_irq;
  logic           r_first_vld;
  logic [IW-1:0]  r_first_idx;

  logic [NCH-1:0] w_ev;
  logic [NCH-1:0] w_set;
  logic [NCH-1:0] w_clr;
  logic [NCH-1:0] w_en;
  logic [NCH-1:0] w_dis;
  logic [NCH-1:0] w_err_nxt;
  logic [NCH-1:0] w_int_en_nxt;
  logic [IW-1:0]  w_ev_idx;
  logic           w_any_ev;
  logic           w_first_clr;

  assign w_ev  = (cond & ~r_cond_q & EDGE_MASK) | (cond & ~EDGE_MASK);
  assign w_set = {NCH{SEL_SET}} & ebus_data;
  assign w_clr = {NCH{SEL_CLR}} & ebus_data;
  assign w_en  = {NCH{SEL_EN}}  & ebus_data;
  assign w_dis = {NCH{SEL_DIS}} & ebus_data;

  // Events beat a same-cycle clear; enable beats a same-cycle disable.
  assign w_err_nxt    = w_ev | w_set | (r_err & ~w_clr);
  assign w_int_en_nxt = w_en | (r_int_en & ~w_dis);

  assign w_any_ev    = |w_ev;
  assign w_first_clr = r_first_vld & ~w_err_nxt[r_first_idx];

  always_comb begin
    w_ev_idx = '0;
    for (int i = NCH - 1; i >= 0; i--) begin
      if (w_ev[i]) w_ev_idx = IW'(i);
    end
  end

  always_ff @(posedge clk or negedge RESET_N) begin
    if (!RESET_N) begin
      r_cond_q    <= '0;
      r_err       <= '0;
      r_int_en    <= '0;
      r_irq       <= 1'b0;
      r_first_vld <= 1'b0;
      r_first_idx <= '0;
    end else begin
      r_cond_q <= cond;
      r_err    <= w_err_nxt;
      r_int_en <= w_int_en_nxt;
      r_irq    <= |(r_err & r_int_en);
      // A capture may replace the old one in the very cycle its flag is cleared.
      if ((!r_first_vld || w_first_clr) && w_any_ev) begin
        r_first_vld <= 1'b1;
        r_first_idx <= w_ev_idx;
      end else if (w_first_clr) begin
        r_first_vld <= 1'b0;
      end
    end
  end

`ifdef APR_COND_COUNT_EN
  logic [3:0] r_cnt [NCH];

  always_ff @(posedge clk or negedge RESET_N) begin
    if (!RESET_N) begin
      for (int i = 0; i < NCH; i++) r_cnt[i] <= 4'h0;
    end else begin
      for (int i = 0; i < NCH; i++) begin
        if (w_clr[i])
          r_cnt[i] <= 4'h0;
        else if (w_ev[i] && (r_cnt[i] != 4'hF))
          r_cnt[i] <= r_cnt[i] + 4'h1;
      end
    end
  end

  assign cnt_data = r_cnt[cnt_sel];
`endif

  assign ERR           = r_err;
  assign INT_EN        = r_int_en;
  assign APR_INTERRUPT = r_irq;
  assign FIRST_VLD     = r_first_vld;
  assign FIRST_IDX     = r_first_idx;

endmodule

// File: tb/tb_apr_cond_bank.sv
// Bench for apr_cond_bank: vector table plus hand sequences for edge, counter and reset cases.
module tb_apr_cond_bank;

  typedef struct {
    logic [7:0] ebus;
    logic       set, clr, en, dis;
    logic [7:0] cnd;
    logic [7:0] err, inten;
    logic       irq, vld;
    logic [2:0] idx;
  } vec_t;

  logic       clk = 1'b0;
  logic       RESET_N;
  logic [7:0] ebus_data;
  logic       SEL_SET, SEL_CLR, SEL_EN, SEL_DIS;
  logic [7:0] cond;
  logic [7:0] ERR, INT_EN;
  logic       APR_INTERRUPT, FIRST_VLD;
  logic [2:0] FIRST_IDX;
`ifdef APR_COND_COUNT_EN
  logic [2:0] cnt_sel;
  logic [3:0] cnt_data;
`endif

  int n_chk  = 0;
  int n_fail = 0;
  vec_t sb_q[$];
  vec_t tbl[19];

  always #5 clk = ~clk;

  apr_cond_bank #(.NCH(8), .EDGE_MASK(8'h81)) dut (
    .clk(clk), .RESET_N(RESET_N), .ebus_data(ebus_data),
    .SEL_SET(SEL_SET), .SEL_CLR(SEL_CLR), .SEL_EN(SEL_EN), .SEL_DIS(SEL_DIS),
    .cond(cond),
`ifdef APR_COND_COUNT_EN
    .cnt_sel(cnt_sel), .cnt_data(cnt_data),
`endif
    .ERR(ERR), .INT_EN(INT_EN), .APR_INTERRUPT(APR_INTERRUPT),
    .FIRST_VLD(FIRST_VLD), .FIRST_IDX(FIRST_IDX)
  );

  function automatic vec_t mk(logic [7:0] ebus, logic s, logic c, logic e, logic d,
                              logic [7:0] cn, logic [7:0] er, logic [7:0] ie,
                              logic irq, logic vld, logic [2:0] idx);
    vec_t v;
    v.ebus = ebus; v.set = s; v.clr = c; v.en = e; v.dis = d; v.cnd = cn;
    v.err = er; v.inten = ie; v.irq = irq; v.vld = vld; v.idx = idx;
    return v;
  endfunction

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Drive one cycle of stimulus, queue its expected outcome, then check after the edge.
  task automatic step(vec_t v, string tag);
    vec_t e;
    @(negedge clk);
    ebus_data = v.ebus; SEL_SET = v.set; SEL_CLR = v.clr;
    SEL_EN = v.en; SEL_DIS = v.dis; cond = v.cnd;
    sb_q.push_back(v);
    @(posedge clk);
    #1;
    e = sb_q.pop_front();
    chk({tag, ".err"},   ERR,           e.err);
    chk({tag, ".inten"}, INT_EN,        e.inten);
    chk({tag, ".irq"},   APR_INTERRUPT, e.irq);
    chk({tag, ".vld"},   FIRST_VLD,     e.vld);
    chk({tag, ".idx"},   FIRST_IDX,     e.idx);
  endtask

  initial begin
    //             ebus   S C E D  cond   err    inten  irq vld idx
    tbl[0]  = mk(8'h00, 0,0,0,0, 8'h00, 8'h00, 8'h00, 0, 0, 3'd0);
    tbl[1]  = mk(8'h04, 0,0,1,0, 8'h00, 8'h00, 8'h04, 0, 0, 3'd0);
    tbl[2]  = mk(8'h00, 0,0,0,0, 8'h04, 8'h04, 8'h04, 0, 1, 3'd2);
    tbl[3]  = mk(8'h00, 0,0,0,0, 8'h00, 8'h04, 8'h04, 1, 1, 3'd2);
    tbl[4]  = mk(8'h04, 0,1,0,0, 8'h00, 8'h00, 8'h04, 1, 0, 3'd2);
    tbl[5]  = mk(8'h00, 0,0,0,0, 8'h22, 8'h22, 8'h04, 0, 1, 3'd1);
    tbl[6]  = mk(8'h00, 0,0,0,0, 8'h00, 8'h22, 8'h04, 0, 1, 3'd1);
    tbl[7]  = mk(8'h02, 0,1,0,0, 8'h00, 8'h20, 8'h04, 0, 0, 3'd1);
    tbl[8]  = mk(8'h08, 0,1,0,0, 8'h08, 8'h28, 8'h04, 0, 1, 3'd3);
    tbl[9]  = mk(8'h08, 0,0,1,1, 8'h00, 8'h28, 8'h0C, 0, 1, 3'd3);
    tbl[10] = mk(8'h00, 0,0,0,0, 8'h00, 8'h28, 8'h0C, 1, 1, 3'd3);
    tbl[11] = mk(8'h0C, 0,0,0,1, 8'h00, 8'h28, 8'h00, 1, 1, 3'd3);
    tbl[12] = mk(8'h00, 0,0,0,0, 8'h00, 8'h28, 8'h00, 0, 1, 3'd3);
    tbl[13] = mk(8'h28, 0,1,0,0, 8'h00, 8'h00, 8'h00, 0, 0, 3'd3);
    tbl[14] = mk(8'h41, 1,0,0,0, 8'h00, 8'h41, 8'h00, 0, 0, 3'd3);
    tbl[15] = mk(8'h00, 0,0,0,0, 8'h10, 8'h51, 8'h00, 0, 1, 3'd4);
    tbl[16] = mk(8'h10, 0,1,0,0, 8'h02, 8'h43, 8'h00, 0, 1, 3'd1);
    tbl[17] = mk(8'h04, 1,0,0,0, 8'h00, 8'h47, 8'h00, 0, 1, 3'd1);
    tbl[18] = mk(8'hFF, 0,1,0,0, 8'h00, 8'h00, 8'h00, 0, 0, 3'd1);

    RESET_N = 1'b0; ebus_data = '0; cond = '0;
    SEL_SET = 0; SEL_CLR = 0; SEL_EN = 0; SEL_DIS = 0;
`ifdef APR_COND_COUNT_EN
    cnt_sel = 3'd0;
`endif
    #12;
    chk("rst.err", ERR, 0);
    chk("rst.inten", INT_EN, 0);
    chk("rst.irq", APR_INTERRUPT, 0);
    chk("rst.vld", FIRST_VLD, 0);
    chk("rst.idx", FIRST_IDX, 0);
    #1 RESET_N = 1'b1;

    for (int i = 0; i < 19; i++) step(tbl[i], $sformatf("tbl%0d", i));

    // Edge channel 7 held high for 10 cycles, cleared in cycle 5.
    for (int c = 1; c <= 10; c++) begin
      if (c < 5)       step(mk(8'h00, 0,0,0,0, 8'h80, 8'h80, 8'h00, 0, 1, 3'd7), "edge7");
      else if (c == 5) step(mk(8'h80, 0,1,0,0, 8'h80, 8'h00, 8'h00, 0, 0, 3'd7), "edge7clr");
      else             step(mk(8'h00, 0,0,0,0, 8'h80, 8'h00, 8'h00, 0, 0, 3'd7), "edge7hold");
    end
    step(mk(8'h00, 0,0,0,0, 8'h00, 8'h00, 8'h00, 0, 0, 3'd7), "edge7drop");
`ifdef APR_COND_COUNT_EN
    cnt_sel = 3'd7; #1;
    chk("cnt7", cnt_data, 1);
    cnt_sel = 3'd0;
`endif

    // Twenty edge events on channel 0, then a clear coincident with a new event.
    for (int k = 0; k < 20; k++) begin
      step(mk(8'h00, 0,0,0,0, 8'h01, 8'h01, 8'h00, 0, 1, 3'd0), "ev0hi");
      step(mk(8'h00, 0,0,0,0, 8'h00, 8'h01, 8'h00, 0, 1, 3'd0), "ev0lo");
    end
`ifdef APR_COND_COUNT_EN
    chk("cnt0sat", cnt_data, 15);
`endif
    step(mk(8'h01, 0,1,0,0, 8'h01, 8'h01, 8'h00, 0, 1, 3'd0), "ev0clr");
`ifdef APR_COND_COUNT_EN
    chk("cnt0clr", cnt_data, 0);
`endif
    step(mk(8'h00, 0,0,0,0, 8'h00, 8'h01, 8'h00, 0, 1, 3'd0), "ev0idle");

    // Asynchronous reset between edges with everything set.
    step(mk(8'hFF, 1,0,1,0, 8'h00, 8'hFF, 8'hFF, 0, 1, 3'd0), "allset");
    step(mk(8'h00, 0,0,0,0, 8'h00, 8'hFF, 8'hFF, 1, 1, 3'd0), "allirq");
    #2 RESET_N = 1'b0;
    #1;
    chk("arst.err", ERR, 0);
    chk("arst.inten", INT_EN, 0);
    chk("arst.irq", APR_INTERRUPT, 0);
    chk("arst.vld", FIRST_VLD, 0);
    chk("arst.idx", FIRST_IDX, 0);
    cond = 8'h02;
    RESET_N = 1'b1;
    step(mk(8'h00, 0,0,0,0, 8'h02, 8'h02, 8'h00, 0, 1, 3'd1), "postrst");
    step(mk(8'h00, 0,0,0,0, 8'h00, 8'h02, 8'h00, 0, 1, 3'd1), "postrst2");

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
